pipe_float32_to_fixed_point: RTL
================================

Name: pipe_float32_to_fixed_point

Overview:
Pipelined converter from IEEE-754 single precision to signed two's-complement fixed point with WOI integer bits (incl. sign) and WOF fraction bits. It is the inverse of the fixed-to-float conversion path and sits on float-producing datapaths (soft-float results, host-supplied coefficients) that feed fixed-point arithmetic. It uses a 3-stage valid/ready pipeline with whole-pipe stall under backpressure.

Parameters:
WOI, 16, output integer bit count including sign bit (2..32)
WOF, 16, output fraction bit count (0..32)
ROOF, 1, 1 = saturate on overflow; 0 = wrap (keep low WOI+WOF bits of exact two's-complement result)
ROUND, 1, 1 = round half away from zero at the WOF LSB; 0 = truncate magnitude toward zero

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
i_valid  input  1  input word valid
i_ready  output  1  pipe can accept (combinational: ~o_valid | o_ready)
i_float  input  32  IEEE-754 single
o_valid  output  1  output word valid
o_ready  input  1  downstream accepts
o_fixed  output  WOI+WOF  fixed-point result
o_upflow  output  1  overflow / inf / NaN flag, qualified by o_valid
o_downflow  output  1  nonzero input rounded to zero, qualified by o_valid

Behaviour:
- Reset (async assert, sync release): stage valids, o_valid, o_fixed, o_upflow and o_downflow = 0. Pipeline contents discarded; no in-flight word is emitted after reset.
- Advance enable en = ~o_valid | o_ready. When en=1, all stages shift one step. When en=0, all stages hold, including data/flags of empty stages.
- Transfer in: i_valid & i_ready. Transfer out: o_valid & o_ready.
- Latency 3 cycles with en held high. Throughput 1 word/cycle. Order preserved. No bubble compression.
- Outputs are stable while o_valid & ~o_ready.
- S1 (unpack/classify): s=bit31, e=bits30:23, m=bits22:0.
  - e=0: zero, denormals flushed.
  - e=255: inf if m=0, else NaN.
  - Otherwise the magnitude is M={1,m} (24b), with shift k = e-127-23+WOF.
- S2 (align/round):
  - k>=0: mag = M<<k, computed in a width sufficient to detect overflow (a k larger than the output width forces overflow).
  - k<0: mag = M>>-k. With ROUND=1, add 1 if the highest dropped bit is 1 (half away from zero).
  - A k below -25 gives mag=0.
- S3 (sign/saturate/flags):
  - Exact result r = s ? -mag : mag.
  - Representable range is [-2^(WOI+WOF-1), 2^(WOI+WOF-1)-1]. Exactly -2^(WOI+WOF-1) is legal with no upflow.
  - Out of range: o_upflow=1. If ROOF=1, saturate to max positive/min negative by sign; if ROOF=0, wrap.
  - Inf: o_upflow=1, signed saturation (ROOF=1) or 0 (ROOF=0).
  - NaN: o_upflow=1, output max positive (ROOF=1) or 0 (ROOF=0).
  - o_downflow=1 iff the input is nonzero finite (including denormal) and the final result is 0. A result of zero, positive or negative, gives o_fixed=0 with no flags.
  - o_upflow and o_downflow are never both 1.
- Simultaneous output accept and input present: both transfer in the same cycle.

Test Plan:
- Defaults. Send 0x3F800000 (1.0) -> o_fixed 0x00010000 three cycles later, no flags. Send 0xBFC00000 (-1.5) -> 0xFFFE8000.
- Range boundary:
  - 0xC7000000 (-32768.0) -> 0x80000000, upflow=0.
  - 0x471C4000 (40000.0) -> 0x7FFFFFFF, upflow=1.
  - 0xFF800000 (-inf) -> 0x80000000, upflow=1.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, upflow=1.
- Rounding/downflow:
  - 0x37000000 (2^-17) -> 0x00000001, downflow=0.
  - 0xB7000000 -> 0xFFFFFFFF.
  - 0x36800000 (2^-18) -> 0x00000000, downflow=1.
  - 0x00000001 (denormal) -> 0, downflow=1.
  - 0x80000000 -> 0, no flags.
  - With ROUND=0, 0x37000000 -> 0, downflow=1.
- Backpressure: stream 6 words back-to-back while o_ready is low from cycle 4 for 5 cycles. Required:
  - i_ready low during the stall.
  - o_fixed/flags held constant.
  - All 6 results emerge in order.
  - No word is lost or duplicated.
- Reset mid-operation: 2 words in flight, pull rstn low between clock edges -> o_valid drops immediately. After release, o_valid stays 0 until a new input arrives 3 cycles earlier.
- ROOF=0: 0x471C4000 (40000.0) -> 0x9C400000 (wrapped), upflow=1.

Source files
------------

// File: rtl/pipe_float32_to_fixed_point_if.sv
// Valid/ready stream bundle for the float32 -> fixed-point converter.
// The slave view belongs to the converter; the master view belongs to whatever drives and consumes it.
interface pipe_float32_to_fixed_point_if #(
  parameter int WOI = 16,
  parameter int WOF = 16
);
  logic                 i_valid;
  logic                 i_ready;
  logic [31:0]          i_float;
  logic                 o_valid;
  logic                 o_ready;
  logic [WOI+WOF-1:0]   o_fixed;
  logic                 o_upflow;
  logic                 o_downflow;

  modport slave (
    input  i_valid, i_float, o_ready,
    output i_ready, o_valid, o_fixed, o_upflow, o_downflow
  );

  modport master (
    output i_valid, i_float, o_ready,
    input  i_ready, o_valid, o_fixed, o_upflow, o_downflow
  );
endinterface

// File: rtl/pipe_float32_to_fixed_point.sv
// IEEE-754 single -> signed WOI.WOF fixed point, 3-stage pipe (unpack, align/round, sign/saturate).
// The whole pipe advances together; a stalled output freezes every stage.
module pipe_float32_to_fixed_point #(
  parameter int WOI   = 16,
  parameter int WOF   = 16,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  pipe_float32_to_fixed_point_if.slave   bus
);
  localparam int W  = WOI + WOF;
  localparam int SW = W + 25;

  typedef enum logic [2:0] {CLS_ZERO, CLS_DENORM, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

  logic en;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  cls_e              s1_cls_q,   s1_cls_d;
  logic [23:0]       s1_man_q,   s1_man_d;
  logic signed [9:0] s1_k_q,     s1_k_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q,  s2_sign_d;
  cls_e              s2_cls_q,   s2_cls_d;
  logic [W-1:0]      s2_mag_q,   s2_mag_d;
  logic              s2_big_q,   s2_big_d;

  logic              o_valid_q,    o_valid_d;
  logic [W-1:0]      o_fixed_q,    o_fixed_d;
  logic              o_upflow_q,   o_upflow_d;
  logic              o_downflow_q, o_downflow_d;

  assign en             = ~o_valid_q | bus.o_ready;
  assign bus.i_ready    = en;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_fixed    = o_fixed_q;
  assign bus.o_upflow   = o_upflow_q;
  assign bus.o_downflow = o_downflow_q;

  // S1: classify and form the binary-point shift k = e - 150 + WOF.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves a signal unassigned and no latch is inferred.
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_man_d   = s1_man_q;
    s1_k_d     = s1_k_q;
    if (en) begin
      s1_valid_d = bus.i_valid;
      s1_sign_d  = bus.i_float[31];
      s1_man_d   = {1'b1, bus.i_float[22:0]};
      s1_k_d     = 10'(int'(bus.i_float[30:23]) - 150 + WOF);
      if (bus.i_float[30:23] == 8'd0)
        s1_cls_d = (bus.i_float[22:0] == '0) ? CLS_ZERO : CLS_DENORM;
      else if (bus.i_float[30:23] == 8'hFF)
        s1_cls_d = (bus.i_float[22:0] == '0) ? CLS_INF : CLS_NAN;
      else
        s1_cls_d = CLS_NORM;
    end
  end

  // S2: magnitude aligned to the output LSB; s2_big flags a magnitude of 2^W or more.
  always_comb begin
    logic [SW-1:0] wide;
    logic [24:0]   man_x;
    logic [24:0]   shr;
    logic [4:0]    rnd_idx;
    logic          force_big;
    int            k;
    int            sh;

    wide      = '0;
    man_x     = {1'b0, s1_man_q};
    shr       = '0;
    rnd_idx   = '0;
    force_big = 1'b0;
    k         = int'(s1_k_q);
    sh        = 0;

    if (k >= 0) begin
      // Beyond W the low W bits are all zero and the value is certainly out of range.
      if (k > W) force_big = 1'b1;
      else       wide      = SW'(s1_man_q) << k;
    end else begin
      sh = -k;
      if (sh <= 25) begin
        shr     = man_x >> sh;
        rnd_idx = 5'(sh - 1);
        if (ROUND != 0) shr = shr + 25'(man_x[rnd_idx]);
        wide = SW'(shr);
      end
    end

    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_cls_d   = s2_cls_q;
    s2_mag_d   = s2_mag_q;
    s2_big_d   = s2_big_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_cls_d   = s1_cls_q;
      s2_mag_d   = wide[W-1:0];
      s2_big_d   = force_big | (|wide[SW-1:W]);
    end
  end

  // S3: apply sign, detect range overflow, saturate or wrap, raise flags.
  always_comb begin
    logic [W-1:0] max_pos;
    logic [W-1:0] min_neg;
    logic [W-1:0] wrapped;
    logic [W-1:0] sat;
    logic         ovf;
    logic [W-1:0] fixed;
    logic         up;
    logic         dn;

    max_pos = {1'b0, {(W-1){1'b1}}};
    min_neg = {1'b1, {(W-1){1'b0}}};
    wrapped = s2_sign_q ? (~s2_mag_q) + W'(1) : s2_mag_q;
    sat     = s2_sign_q ? min_neg : max_pos;
    // Exactly 2^(W-1) is still legal when negative.
    ovf     = s2_big_q | (s2_mag_q[W-1] & ~(s2_sign_q & (s2_mag_q[W-2:0] == '0)));
    fixed   = '0;
    up      = 1'b0;
    dn      = 1'b0;

    unique case (s2_cls_q)
      CLS_DENORM: dn = 1'b1;
      CLS_NORM: begin
        if (ovf) begin
          up    = 1'b1;
          fixed = (ROOF != 0) ? sat : wrapped;
        end else begin
          fixed = wrapped;
          dn    = (s2_mag_q == '0);
        end
      end
      CLS_INF: begin
        up    = 1'b1;
        fixed = (ROOF != 0) ? sat : '0;
      end
      CLS_NAN: begin
        up    = 1'b1;
        fixed = (ROOF != 0) ? max_pos : '0;
      end
      default: ;
    endcase

    o_valid_d    = o_valid_q;
    o_fixed_d    = o_fixed_q;
    o_upflow_d   = o_upflow_q;
    o_downflow_d = o_downflow_q;
    if (en) begin
      o_valid_d    = s2_valid_q;
      o_fixed_d    = fixed;
      o_upflow_d   = up;
      o_downflow_d = dn;
    end
  end

  // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_cls_q     <= CLS_ZERO;
      s1_man_q     <= '0;
      s1_k_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_cls_q     <= CLS_ZERO;
      s2_mag_q     <= '0;
      s2_big_q     <= 1'b0;
      o_valid_q    <= 1'b0;
      o_fixed_q    <= '0;
      o_upflow_q   <= 1'b0;
      o_downflow_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_cls_q     <= s1_cls_d;
      s1_man_q     <= s1_man_d;
      s1_k_q       <= s1_k_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_cls_q     <= s2_cls_d;
      s2_mag_q     <= s2_mag_d;
      s2_big_q     <= s2_big_d;
      o_valid_q    <= o_valid_d;
      o_fixed_q    <= o_fixed_d;
      o_upflow_q   <= o_upflow_d;
      o_downflow_q <= o_downflow_d;
    end
  end

endmodule
